// File: rtl/segre_pkg.sv
// -----------------------------------------------------------------------------
// segre_pkg
// Shared definitions for the Segre core memory path.
//   ADDR_SIZE / WORD_SIZE : address and data bus widths
//   memop_data_type_e     : access size encoding (BYTE/HALF/WORD)
//   arb_state_e           : memory arbiter FSM states
//   GRANT_IF / GRANT_LSU  : encoding of the arbiter's last-grant record
// -----------------------------------------------------------------------------
package segre_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_BUSY  = 2'b01,
        LSU_BUSY = 2'b10,
        RESP     = 2'b11
    } arb_state_e;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/segre_mem_arbiter.sv
// -----------------------------------------------------------------------------
// segre_mem_arbiter
// Serialises the instruction-fetch (IF) and load/store (LSU) masters onto the
// single-ported memory bus, one transaction at a time. The granted request is
// latched, held on the memory bus until mem_ready_i, and answered with a
// registered one-cycle ready pulse to that master only.
//
// Ports:
//   clk_i, rsn_i                 clock, asynchronous active-low reset
//   if_req_i, if_addr_i          fetch request / address
//   if_rd_data_o, if_ready_o     fetched word / completion pulse
//   lsu_req_i, lsu_we_i          data request / 1 = store
//   lsu_addr_i, lsu_wr_data_i    data address / store data
//   lsu_data_type_i              access size (BYTE/HALF/WORD)
//   lsu_rd_data_o, lsu_ready_o   load data / completion pulse
//   mem_rd_o, mem_wr_o           memory read / write strobes
//   addr_o, mem_wr_data_o        memory address / write data
//   mem_data_type_o              memory access size
//   mem_rd_data_i, mem_ready_i   memory read data / completion
//
// Build option:
//   SEGRE_ARB_RR_EN  defined   -> round-robin between masters on contention
//                    undefined -> fixed priority, LSU wins over IF
// -----------------------------------------------------------------------------
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = segre_pkg::ADDR_SIZE,
    parameter int WORD_SIZE = segre_pkg::WORD_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 if_req_i,
    input  logic [ADDR_SIZE-1:0] if_addr_i,
    output logic [WORD_SIZE-1:0] if_rd_data_o,
    output logic                 if_ready_o,
    input  logic                 lsu_req_i,
    input  logic                 lsu_we_i,
    input  logic [ADDR_SIZE-1:0] lsu_addr_i,
    input  logic [WORD_SIZE-1:0] lsu_wr_data_i,
    input  logic [1:0]           lsu_data_type_i,
    output logic [WORD_SIZE-1:0] lsu_rd_data_o,
    output logic                 lsu_ready_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic [WORD_SIZE-1:0] mem_wr_data_o,
    output logic [1:0]           mem_data_type_o,
    input  logic [WORD_SIZE-1:0] mem_rd_data_i,
    input  logic                 mem_ready_i
);
    import segre_pkg::*;

    arb_state_e           state_reg;
    logic                 mem_rd_reg;
    logic                 mem_wr_reg;
    logic [ADDR_SIZE-1:0] addr_reg;
    logic [WORD_SIZE-1:0] wr_data_reg;
    logic [1:0]           data_type_reg;
    logic [WORD_SIZE-1:0] if_rd_data_reg;
    logic [WORD_SIZE-1:0] lsu_rd_data_reg;
    logic                 if_ready_reg;
    logic                 lsu_ready_reg;
    logic                 grant_lsu;

`ifdef SEGRE_ARB_RR_EN
    // Remembers which master won the last IDLE decision; on contention the
    // other master is preferred so neither can be starved.
    logic last_grant_reg;

    assign grant_lsu = lsu_req_i && (!if_req_i || (last_grant_reg == GRANT_IF));

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            last_grant_reg <= GRANT_IF;
        end else if (state_reg == IDLE) begin
            if (grant_lsu) begin
                last_grant_reg <= GRANT_LSU;
            end else if (if_req_i) begin
                last_grant_reg <= GRANT_IF;
            end
        end
    end
`else
    assign grant_lsu = lsu_req_i;
`endif

    // Single FSM; every bus-facing output is a register updated on the
    // transition that changes its value, so the memory sees nothing but flops.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_reg       <= IDLE;
            mem_rd_reg      <= 1'b0;
            mem_wr_reg      <= 1'b0;
            addr_reg        <= '0;
            wr_data_reg     <= '0;
            data_type_reg   <= WORD;
            if_rd_data_reg  <= '0;
            lsu_rd_data_reg <= '0;
            if_ready_reg    <= 1'b0;
            lsu_ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_lsu) begin
                        state_reg     <= LSU_BUSY;
                        addr_reg      <= lsu_addr_i;
                        wr_data_reg   <= lsu_wr_data_i;
                        data_type_reg <= lsu_data_type_i;
                        mem_rd_reg    <= !lsu_we_i;
                        mem_wr_reg    <= lsu_we_i;
                    end else if (if_req_i) begin
                        state_reg     <= IF_BUSY;
                        addr_reg      <= if_addr_i;
                        data_type_reg <= WORD;
                        mem_rd_reg    <= 1'b1;
                        mem_wr_reg    <= 1'b0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ready_i) begin
                        state_reg      <= RESP;
                        if_rd_data_reg <= mem_rd_data_i;
                        if_ready_reg   <= 1'b1;
                        mem_rd_reg     <= 1'b0;
                        mem_wr_reg     <= 1'b0;
                    end
                end
                LSU_BUSY: begin
                    if (mem_ready_i) begin
                        state_reg <= RESP;
                        // A store leaves the previous load data visible.
                        if (!mem_wr_reg) begin
                            lsu_rd_data_reg <= mem_rd_data_i;
                        end
                        lsu_ready_reg <= 1'b1;
                        mem_rd_reg    <= 1'b0;
                        mem_wr_reg    <= 1'b0;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    if_ready_reg  <= 1'b0;
                    lsu_ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_o        = mem_rd_reg;
    assign mem_wr_o        = mem_wr_reg;
    assign addr_o          = addr_reg;
    assign mem_wr_data_o   = wr_data_reg;
    assign mem_data_type_o = data_type_reg;
    assign if_rd_data_o    = if_rd_data_reg;
    assign if_ready_o      = if_ready_reg;
    assign lsu_rd_data_o   = lsu_rd_data_reg;
    assign lsu_ready_o     = lsu_ready_reg;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_segre_mem_arbiter
// Directed bench for segre_mem_arbiter. A per-cycle task (tick) samples the
// DUT on the falling edge, keeps pulse/strobe statistics, plays a simple memory
// that answers after a programmable number of strobe cycles, and lets masters
// drop their request when they see their ready pulse.
// Covers both the fixed-priority build and, with SEGRE_ARB_RR_EN, round-robin.
// -----------------------------------------------------------------------------
module tb_segre_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rd_data_o;
    logic        if_ready_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wr_data_i;
    logic [1:0]  lsu_data_type_i;
    logic [31:0] lsu_rd_data_o;
    logic        lsu_ready_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [31:0] addr_o;
    logic [31:0] mem_wr_data_o;
    logic [1:0]  mem_data_type_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_ready_i;

    segre_mem_arbiter dut (
        .clk_i           (clk_i),
        .rsn_i           (rsn_i),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_rd_data_o    (if_rd_data_o),
        .if_ready_o      (if_ready_o),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_wr_data_i   (lsu_wr_data_i),
        .lsu_data_type_i (lsu_data_type_i),
        .lsu_rd_data_o   (lsu_rd_data_o),
        .lsu_ready_o     (lsu_ready_o),
        .mem_rd_o        (mem_rd_o),
        .mem_wr_o        (mem_wr_o),
        .addr_o          (addr_o),
        .mem_wr_data_o   (mem_wr_data_o),
        .mem_data_type_o (mem_data_type_o),
        .mem_rd_data_i   (mem_rd_data_i),
        .mem_ready_i     (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // statistics and memory model state
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rd_cycles, wr_cycles, both_cnt;
    int          if_pulses, lsu_pulses;
    int          if_pulse_cyc, lsu_pulse_cyc;
    int          busy_cnt = 0;
    int          lat = 1;
    int          held_stop = 0;
    int          order[$];
    logic        force_ready = 1'b0;
    logic        auto_drop = 1'b1;
    logic        addr_data = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_type;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic clr();
        rd_cycles  = 0;
        wr_cycles  = 0;
        if_pulses  = 0;
        lsu_pulses = 0;
        order.delete();
    endtask

    task automatic tick();
        @(negedge clk_i);
        cyc++;
        if (mem_rd_o && mem_wr_o) both_cnt++;
        if (mem_rd_o) rd_cycles++;
        if (mem_wr_o) wr_cycles++;
        if (if_ready_o) begin
            if_pulses++;
            if_pulse_cyc = cyc;
            order.push_back(0);
            if (auto_drop) if_req_i = 1'b0;
        end
        if (lsu_ready_o) begin
            lsu_pulses++;
            lsu_pulse_cyc = cyc;
            order.push_back(1);
            if (auto_drop) lsu_req_i = 1'b0;
        end
        if (held_stop > 0 && (if_pulses + lsu_pulses) >= held_stop) begin
            if_req_i  = 1'b0;
            lsu_req_i = 1'b0;
        end
        if (mem_rd_o || mem_wr_o) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
                s_addr  = addr_o;
                s_wdata = mem_wr_data_o;
                s_type  = mem_data_type_o;
            end
            mem_ready_i   = (busy_cnt == lat);
            mem_rd_data_i = addr_data ? (addr_o ^ 32'h5A5A_0000) : rdata;
        end else begin
            busy_cnt    = 0;
            mem_ready_i = force_ready;
        end
    endtask

    // Advance until the total pulse count reaches target (bounded), then check it.
    task automatic wait_pulses(input string tag, input int target);
        int n;
        n = 0;
        while ((if_pulses + lsu_pulses) < target && n < 200) begin
            tick();
            n++;
        end
        check(tag, if_pulses + lsu_pulses, target);
    endtask

    int req_cyc;

    initial begin
        rsn_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0;
        lsu_wr_data_i = '0; lsu_data_type_i = 2'b10;
        mem_rd_data_i = '0; mem_ready_i = 1'b0;
        both_cnt = 0;
        clr();

        // ---- reset state ----
        tick(); tick();
        check("rst_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_type_word", {30'd0, mem_data_type_o}, 32'd2);
        check("rst_ready", {30'd0, if_ready_o, lsu_ready_o}, 32'd0);
        check("rst_if_data", if_rd_data_o, 32'd0);
        check("rst_lsu_data", lsu_rd_data_o, 32'd0);
        rsn_i = 1'b1;
        tick();

        // ---- mem_ready in IDLE is ignored ----
        clr();
        force_ready = 1'b1;
        tick(); tick(); tick();
        force_ready = 1'b0;
        tick(); tick();
        check("idle_ready_pulses", if_pulses + lsu_pulses, 0);
        check("idle_ready_strobes", rd_cycles + wr_cycles, 0);

        // ---- lone fetch, 2-cycle memory ----
        clr();
        lat = 2; rdata = 32'hDEAD_BEEF;
        if_addr_i = 32'h100; if_req_i = 1'b1; req_cyc = cyc;
        wait_pulses("fetch_done", 1);
        tick(); tick(); tick();
        check("fetch_rd_cycles", rd_cycles, 2);
        check("fetch_wr_cycles", wr_cycles, 0);
        check("fetch_addr", s_addr, 32'h100);
        check("fetch_type", {30'd0, s_type}, 32'd2);
        check("fetch_data", if_rd_data_o, 32'hDEAD_BEEF);
        check("fetch_if_pulses", if_pulses, 1);
        check("fetch_lsu_pulses", lsu_pulses, 0);
        check("fetch_latency", if_pulse_cyc - req_cyc, 3);

        // ---- LSU word load, then HALF store must not disturb load data ----
        clr();
        lat = 1; rdata = 32'hCAFE_F00D;
        lsu_we_i = 1'b0; lsu_addr_i = 32'h300; lsu_data_type_i = 2'b10; lsu_req_i = 1'b1;
        wait_pulses("load_done", 1);
        tick();
        check("load_data", lsu_rd_data_o, 32'hCAFE_F00D);
        check("load_if_pulses", if_pulses, 0);

        clr();
        lat = 2; rdata = 32'h1111_2222;
        lsu_we_i = 1'b1; lsu_addr_i = 32'h204; lsu_wr_data_i = 32'h1234;
        lsu_data_type_i = 2'b01; lsu_req_i = 1'b1;
        wait_pulses("store_done", 1);
        tick(); tick();
        check("store_wr_cycles", wr_cycles, 2);
        check("store_rd_cycles", rd_cycles, 0);
        check("store_addr", s_addr, 32'h204);
        check("store_wdata", s_wdata, 32'h1234);
        check("store_type_half", {30'd0, s_type}, 32'd1);
        check("store_lsu_pulses", lsu_pulses, 1);
        check("store_keeps_rdata", lsu_rd_data_o, 32'hCAFE_F00D);
        lsu_we_i = 1'b0;

`ifdef SEGRE_ARB_RR_EN
        // ---- both held; last grant was LSU, so IF, LSU, IF, LSU ----
        clr();
        lat = 1; addr_data = 1'b1; auto_drop = 1'b0; held_stop = 4;
        if_addr_i = 32'h400; lsu_addr_i = 32'h500; lsu_data_type_i = 2'b10;
        if_req_i = 1'b1; lsu_req_i = 1'b1;
        wait_pulses("rr_done", 4);
        tick(); tick(); tick(); tick();
        check("rr_total", if_pulses + lsu_pulses, 4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            check($sformatf("rr_grant%0d", i), order[i], i % 2);
        end
        check("rr_if_data", if_rd_data_o, 32'h5A5A_0400);
        check("rr_lsu_data", lsu_rd_data_o, 32'h5A5A_0500);
        held_stop = 0; auto_drop = 1'b1; addr_data = 1'b0;
`else
        // ---- simultaneous requests, fixed priority: LSU then IF ----
        clr();
        lat = 1; addr_data = 1'b1;
        if_addr_i = 32'h400; lsu_addr_i = 32'h500; lsu_data_type_i = 2'b10;
        if_req_i = 1'b1; lsu_req_i = 1'b1;
        wait_pulses("prio_done", 2);
        tick(); tick();
        check("prio_total", if_pulses + lsu_pulses, 2);
        if (order.size() == 2) begin
            check("prio_first_lsu", order[0], 1);
            check("prio_second_if", order[1], 0);
        end else begin
            check("prio_order_len", order.size(), 2);
        end
        check("prio_gap", if_pulse_cyc - lsu_pulse_cyc, 3);
        check("prio_if_data", if_rd_data_o, 32'h5A5A_0400);
        check("prio_lsu_data", lsu_rd_data_o, 32'h5A5A_0500);
        addr_data = 1'b0;
`endif

        // ---- async reset in LSU_BUSY before mem_ready ----
        clr();
        lat = 1000;
        lsu_we_i = 1'b0; lsu_addr_i = 32'h700; lsu_req_i = 1'b1;
        tick(); tick();
        check("busy_strobe_up", {31'd0, mem_rd_o}, 32'd1);
        rsn_i = 1'b0;
        #1;
        check("rst_busy_strobes", {30'd0, mem_rd_o, mem_wr_o}, 32'd0);
        lsu_req_i = 1'b0;
        tick(); tick();
        rsn_i = 1'b1;
        tick(); tick(); tick();
        check("rst_busy_no_pulse", lsu_pulses, 0);

        // ---- zero-wait memory after reset; held request answered once ----
        clr();
        lat = 1; rdata = 32'h0BAD_F00D;
        if_addr_i = 32'h600; if_req_i = 1'b1; req_cyc = cyc;
        wait_pulses("zw_done", 1);
        check("zw_latency", if_pulse_cyc - req_cyc, 2);
        tick(); tick(); tick(); tick(); tick();
        check("zw_single_pulse", if_pulses, 1);
        check("zw_rd_cycles", rd_cycles, 1);
        check("zw_data", if_rd_data_o, 32'h0BAD_F00D);

        check("strobes_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Two-master arbiter between the Segre core's instruction-fetch (IF) and load/store (LSU) ports and the single-ported `memory` model. It serialises one transaction at a time onto the shared memory bus. It holds address, control and data stable until `mem_ready_i` arrives. It then returns a registered one-cycle response to the master that was granted.

## Interface
Parameters:
- ADDR_SIZE, 32, address width (from segre_pkg)
- WORD_SIZE, 32, data width (from segre_pkg)

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset; one clock, reset asynchronous active-low
- if_req_i  in  1  fetch request; held until if_ready_o
- if_addr_i  in  ADDR_SIZE  fetch address
- if_rd_data_o  out  WORD_SIZE  fetched word, valid with if_ready_o
- if_ready_o  out  1  one-cycle fetch completion pulse
- lsu_req_i  in  1  data request; held until lsu_ready_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_addr_i  in  ADDR_SIZE  data address
- lsu_wr_data_i  in  WORD_SIZE  store data
- lsu_data_type_i  in  2  memop_data_type_e (BYTE/HALF/WORD)
- lsu_rd_data_o  out  WORD_SIZE  load data, valid with lsu_ready_o
- lsu_ready_o  out  1  one-cycle data completion pulse
- mem_rd_o  out  1  memory read strobe
- mem_wr_o  out  1  memory write strobe
- addr_o  out  ADDR_SIZE  memory address
- mem_wr_data_o  out  WORD_SIZE  memory write data
- mem_data_type_o  out  2  memory access size
- mem_rd_data_i  in  WORD_SIZE  memory read data
- mem_ready_i  in  1  memory completion

## Operation
- FSM states: IDLE, IF_BUSY, LSU_BUSY, RESP.
- IDLE:
  - If lsu_req_i is high, latch LSU address, data, type and we, then go to LSU_BUSY.
  - Otherwise, if if_req_i is high, latch if_addr_i, force type WORD, then go to IF_BUSY.
  - Otherwise stay in IDLE.
- IF_BUSY / LSU_BUSY:
  - Outputs are driven from the latched registers only. Master inputs are ignored.
  - mem_rd_o is high for a fetch or load; mem_wr_o is high for a store. The strobes are never both high.
  - On mem_ready_i, capture mem_rd_data_i into the granted master's response register and go to RESP.
- RESP:
  - Pulse the granted master's ready output for exactly one cycle.
  - Drop mem_rd_o and mem_wr_o.
  - Go to IDLE.
- A request still high in the cycle after its ready pulse is treated as a new request.
- Stores: lsu_rd_data_o holds its previous value; only lsu_ready_o pulses.
- Outputs never pulse ready to the master that was not granted.
- Reset values:
  - All outputs are 0; mem_data_type_o = WORD.
  - Response registers are 0.
  - State is IDLE.

## Timing
- A request sampled in IDLE at cycle 0 drives the strobe and addr_o from cycle 1.
- If mem_ready_i is seen at cycle k (k ≥ 1), the ready pulse occurs at cycle k+1.
- Minimum round trip: 3 cycles from request to the next IDLE acceptance.
- mem_ready_i is sampled only in the BUSY states. mem_ready_i asserted in IDLE or RESP is ignored.
- Simultaneous if_req_i and lsu_req_i in IDLE: the winner follows Configuration. The loser stays pending and is granted in the next IDLE.
- Asynchronous reset mid-transaction: strobes drop immediately, state returns to IDLE, and no ready pulse is issued. Masters must reissue the request.

## Configuration
- SEGRE_ARB_RR_EN defined:
  - Round-robin arbitration. A last_grant flop, reset to IF, records the last granted master.
  - On a simultaneous request, the master not in last_grant wins.
  - Single requests are granted normally.
- SEGRE_ARB_RR_EN undefined:
  - Fixed priority: LSU always wins over IF.
  - No last_grant flop is present.

## Structure
- segre_pkg holds ADDR_SIZE, WORD_SIZE, memop_data_type_e (BYTE=2'b00, HALF=2'b01, WORD=2'b10) and arb_state_e.
- The block is a single flat module. No sub-module is warranted; the grant decision is a few lines of combinational logic inside the FSM.

## Test plan
- Lone fetch, if_addr_i = 0x100, memory returns 0xDEADBEEF after 2 cycles:
  - mem_rd_o high for exactly 2 cycles, addr_o = 0x100, mem_data_type_o = WORD.
  - if_ready_o pulses once with if_rd_data_o = 0xDEADBEEF.
- LSU store of HALF 0x1234 to 0x204:
  - mem_wr_o high, mem_wr_data_o = 0x1234, mem_data_type_o = HALF.
  - lsu_ready_o pulses once; lsu_rd_data_o is unchanged.
- Both requests at cycle 0, macro undefined:
  - LSU served first.
  - IF granted in the IDLE after the LSU's RESP.
  - Both ready pulses occur, in order LSU then IF.
- Both requests held continuously, macro defined:
  - Grants alternate IF, LSU, IF, LSU.
  - No master is granted twice in a row.
- Reset asserted in LSU_BUSY before mem_ready_i:
  - All strobes are 0 in the same cycle.
  - No lsu_ready_o pulse.
  - After release, the state is IDLE and accepts a new request.
- mem_ready_i asserted in the same cycle as the strobe (zero-wait memory):
  - The ready pulse occurs on cycle 2.
  - A held request gets no double response.
